// File: rtl/boot_loader_pkg.sv
// Shared constants for the serial boot loader: command/reply bytes and the
// loader FSM state encoding.
package boot_loader_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_DUMP  = 8'h44;

  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_HALT = 8'h48;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_IDLE = 5'd0;
  localparam logic [STATE_W-1:0] ST_L_AH = 5'd1;
  localparam logic [STATE_W-1:0] ST_L_AL = 5'd2;
  localparam logic [STATE_W-1:0] ST_L_NH = 5'd3;
  localparam logic [STATE_W-1:0] ST_L_NL = 5'd4;
  localparam logic [STATE_W-1:0] ST_DATA = 5'd5;
  localparam logic [STATE_W-1:0] ST_G_AH = 5'd6;
  localparam logic [STATE_W-1:0] ST_G_AL = 5'd7;
  localparam logic [STATE_W-1:0] ST_RUN  = 5'd8;
  localparam logic [STATE_W-1:0] ST_TX   = 5'd9;
  localparam logic [STATE_W-1:0] ST_D_AH = 5'd10;
  localparam logic [STATE_W-1:0] ST_D_AL = 5'd11;
  localparam logic [STATE_W-1:0] ST_D_NH = 5'd12;
  localparam logic [STATE_W-1:0] ST_D_NL = 5'd13;
  localparam logic [STATE_W-1:0] ST_D_RD = 5'd14;
  localparam logic [STATE_W-1:0] ST_D_W1 = 5'd15;
  localparam logic [STATE_W-1:0] ST_D_W2 = 5'd16;
  localparam logic [STATE_W-1:0] ST_D_TX = 5'd17;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE, S_L_AH = ST_L_AH, S_L_AL = ST_L_AL, S_L_NH = ST_L_NH,
    S_L_NL = ST_L_NL, S_DATA = ST_DATA, S_G_AH = ST_G_AH, S_G_AL = ST_G_AL,
    S_RUN  = ST_RUN,  S_TX   = ST_TX,   S_D_AH = ST_D_AH, S_D_AL = ST_D_AL,
    S_D_NH = ST_D_NH, S_D_NL = ST_D_NL, S_D_RD = ST_D_RD, S_D_W1 = ST_D_W1,
    S_D_W2 = ST_D_W2, S_D_TX = ST_D_TX
  } state_t;

endpackage

// File: rtl/boot_loader_if.sv
// UART, CPU and RAM side signals of the boot loader. master = loader,
// slave = the UART/CPU/RAM environment around it.
interface boot_loader_if #(parameter int addr_width = 9);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic [addr_width-1:0] cpu_raddr;
  logic [addr_width-1:0] cpu_waddr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_write;
  logic                  cpu_halted;
  logic                  cpu_reset;
  logic [addr_width-1:0] start_address;
  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic [7:0]            mem_wdata;
  logic                  mem_write;
  logic [7:0]            mem_rdata;

  modport master (
    input  rx_data, rx_valid, tx_busy, cpu_raddr, cpu_waddr, cpu_wdata,
           cpu_write, cpu_halted, mem_rdata,
    output tx_data, tx_start, cpu_reset, start_address, mem_raddr,
           mem_waddr, mem_wdata, mem_write
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, cpu_raddr, cpu_waddr, cpu_wdata,
           cpu_write, cpu_halted, mem_rdata,
    input  tx_data, tx_start, cpu_reset, start_address, mem_raddr,
           mem_waddr, mem_wdata, mem_write
  );

endinterface

// File: rtl/boot_mem_mux.sv
// RAM port selector: the loader owns the RAM while the CPU is held in reset,
// otherwise the CPU ports pass straight through.
module boot_mem_mux #(
  parameter int addr_width = 9
) (
  input  logic                  sel_loader,
  input  logic [addr_width-1:0] ld_raddr,
  input  logic [addr_width-1:0] ld_waddr,
  input  logic [7:0]            ld_wdata,
  input  logic                  ld_write,
  input  logic [addr_width-1:0] cpu_raddr,
  input  logic [addr_width-1:0] cpu_waddr,
  input  logic [7:0]            cpu_wdata,
  input  logic                  cpu_write,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_write
);

  assign mem_raddr = sel_loader ? ld_raddr : cpu_raddr;
  assign mem_waddr = sel_loader ? ld_waddr : cpu_waddr;
  assign mem_wdata = sel_loader ? ld_wdata : cpu_wdata;
  assign mem_write = sel_loader ? ld_write : cpu_write;

endmodule

// File: rtl/boot_loader.sv
// Serial program loader FSM: loads RAM, starts/stops the CPU and acks over UART.
// Optional RAM dump command enabled by defining BOOT_LOADER_DUMP_EN.
module boot_loader #(
  parameter int addr_width = 9
) (
  input logic           clk,
  input logic           reset,
  boot_loader_if.master bus
);
  import boot_loader_pkg::*;

  state_t                state_reg, state_next;
  state_t                ret_reg, ret_next;
  logic                  cpu_reset_reg, cpu_reset_next;
  logic [addr_width-1:0] start_address_reg, start_address_next;
  logic [7:0]            tx_data_reg, tx_data_next;
  logic                  tx_start_reg, tx_start_next;
  logic [7:0]            tx_byte_reg, tx_byte_next;
  logic [7:0]            hi_reg, hi_next;
  logic [addr_width-1:0] addr_reg, addr_next;
  logic [15:0]           len_reg, len_next;
  logic [addr_width-1:0] ld_raddr_reg, ld_raddr_next;
  logic [addr_width-1:0] ld_waddr_reg, ld_waddr_next;
  logic [7:0]            ld_wdata_reg, ld_wdata_next;
  logic                  ld_write_reg, ld_write_next;
  logic                  halted_q_reg;

  logic        halt_rise;
  logic [15:0] rx_word;

  assign halt_rise = bus.cpu_halted & ~halted_q_reg;
  assign rx_word   = {hi_reg, bus.rx_data};

`ifndef BOOT_LOADER_DUMP_EN
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      ret_reg           <= S_IDLE;
      cpu_reset_reg     <= 1'b1;
      start_address_reg <= '0;
      tx_data_reg       <= 8'h00;
      tx_start_reg      <= 1'b0;
      tx_byte_reg       <= 8'h00;
      hi_reg            <= 8'h00;
      addr_reg          <= '0;
      len_reg           <= 16'h0000;
      ld_raddr_reg      <= '0;
      ld_waddr_reg      <= '0;
      ld_wdata_reg      <= 8'h00;
      ld_write_reg      <= 1'b0;
      halted_q_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      ret_reg           <= ret_next;
      cpu_reset_reg     <= cpu_reset_next;
      start_address_reg <= start_address_next;
      tx_data_reg       <= tx_data_next;
      tx_start_reg      <= tx_start_next;
      tx_byte_reg       <= tx_byte_next;
      hi_reg            <= hi_next;
      addr_reg          <= addr_next;
      len_reg           <= len_next;
      ld_raddr_reg      <= ld_raddr_next;
      ld_waddr_reg      <= ld_waddr_next;
      ld_wdata_reg      <= ld_wdata_next;
      ld_write_reg      <= ld_write_next;
      halted_q_reg      <= bus.cpu_halted;
    end
  end

  always_comb begin
    state_next         = state_reg;
    ret_next           = ret_reg;
    cpu_reset_next     = cpu_reset_reg;
    start_address_next = start_address_reg;
    tx_data_next       = tx_data_reg;
    tx_start_next      = 1'b0;
    tx_byte_next       = tx_byte_reg;
    hi_next            = hi_reg;
    addr_next          = addr_reg;
    len_next           = len_reg;
    ld_raddr_next      = ld_raddr_reg;
    ld_waddr_next      = ld_waddr_reg;
    ld_wdata_next      = ld_wdata_reg;
    ld_write_next      = 1'b0;

    case (state_reg)
      S_IDLE: if (bus.rx_valid) begin
        case (bus.rx_data)
          CMD_LOAD:  state_next = S_L_AH;
          CMD_GO:    state_next = S_G_AH;
          CMD_RESET: begin
            tx_byte_next = RSP_OK;
            ret_next     = S_IDLE;
            state_next   = S_TX;
          end
`ifdef BOOT_LOADER_DUMP_EN
          CMD_DUMP:  state_next = S_D_AH;
`endif
          default: begin
            tx_byte_next = RSP_ERR;
            ret_next     = S_IDLE;
            state_next   = S_TX;
          end
        endcase
      end
      S_L_AH: if (bus.rx_valid) begin
        hi_next    = bus.rx_data;
        state_next = S_L_AL;
      end
      S_L_AL: if (bus.rx_valid) begin
        addr_next  = addr_width'(rx_word);
        state_next = S_L_NH;
      end
      S_L_NH: if (bus.rx_valid) begin
        hi_next    = bus.rx_data;
        state_next = S_L_NL;
      end
      S_L_NL: if (bus.rx_valid) begin
        len_next = rx_word;
        if (rx_word == 16'h0000) begin
          tx_byte_next = RSP_OK;
          ret_next     = S_IDLE;
          state_next   = S_TX;
        end else begin
          state_next = S_DATA;
        end
      end
      // Each byte becomes a one-cycle registered write; address wraps at top of RAM.
      S_DATA: if (bus.rx_valid) begin
        ld_waddr_next = addr_reg;
        ld_wdata_next = bus.rx_data;
        ld_write_next = 1'b1;
        addr_next     = addr_reg + addr_width'(1);
        len_next      = len_reg - 16'd1;
        if (len_reg == 16'd1) begin
          tx_byte_next = RSP_OK;
          ret_next     = S_IDLE;
          state_next   = S_TX;
        end
      end
      S_G_AH: if (bus.rx_valid) begin
        hi_next    = bus.rx_data;
        state_next = S_G_AL;
      end
      S_G_AL: if (bus.rx_valid) begin
        start_address_next = addr_width'(rx_word);
        cpu_reset_next     = 1'b0;
        tx_byte_next       = RSP_OK;
        ret_next           = S_RUN;
        state_next         = S_TX;
      end
      S_RUN: begin
        if (halt_rise) begin
          cpu_reset_next = 1'b1;
          tx_byte_next   = RSP_HALT;
          ret_next       = S_IDLE;
          state_next     = S_TX;
        end else if (bus.rx_valid && bus.rx_data == CMD_RESET) begin
          cpu_reset_next = 1'b1;
          tx_byte_next   = RSP_OK;
          ret_next       = S_IDLE;
          state_next     = S_TX;
        end
      end
      S_TX: if (!bus.tx_busy) begin
        tx_start_next = 1'b1;
        tx_data_next  = tx_byte_reg;
        state_next    = ret_reg;
      end
`ifdef BOOT_LOADER_DUMP_EN
      S_D_AH: if (bus.rx_valid) begin
        hi_next    = bus.rx_data;
        state_next = S_D_AL;
      end
      S_D_AL: if (bus.rx_valid) begin
        addr_next  = addr_width'(rx_word);
        state_next = S_D_NH;
      end
      S_D_NH: if (bus.rx_valid) begin
        hi_next    = bus.rx_data;
        state_next = S_D_NL;
      end
      S_D_NL: if (bus.rx_valid) begin
        len_next   = rx_word;
        state_next = S_D_RD;
      end
      // The remaining count is tested here so N=0 falls straight through to the ack.
      S_D_RD: begin
        if (len_reg == 16'h0000) begin
          tx_byte_next = RSP_OK;
          ret_next     = S_IDLE;
          state_next   = S_TX;
        end else begin
          ld_raddr_next = addr_reg;
          state_next    = S_D_W1;
        end
      end
      S_D_W1: state_next = S_D_W2;
      S_D_W2: state_next = S_D_TX;
      S_D_TX: begin
        tx_byte_next = bus.mem_rdata;
        addr_next    = addr_reg + addr_width'(1);
        len_next     = len_reg - 16'd1;
        ret_next     = S_D_RD;
        state_next   = S_TX;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.cpu_reset     = cpu_reset_reg;
  assign bus.start_address = start_address_reg;
  assign bus.tx_data       = tx_data_reg;
  assign bus.tx_start      = tx_start_reg;

  boot_mem_mux #(.addr_width(addr_width)) u_mem_mux (
    .sel_loader (cpu_reset_reg),
    .ld_raddr   (ld_raddr_reg),
    .ld_waddr   (ld_waddr_reg),
    .ld_wdata   (ld_wdata_reg),
    .ld_write   (ld_write_reg),
    .cpu_raddr  (bus.cpu_raddr),
    .cpu_waddr  (bus.cpu_waddr),
    .cpu_wdata  (bus.cpu_wdata),
    .cpu_write  (bus.cpu_write),
    .mem_raddr  (bus.mem_raddr),
    .mem_waddr  (bus.mem_waddr),
    .mem_wdata  (bus.mem_wdata),
    .mem_write  (bus.mem_write)
  );

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: commands push expected acks/writes into
// queues, a negedge monitor pops and compares whenever the DUT emits one.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int AW   = 9;
  localparam int RAMN = 1 << AW;

  logic clk;
  logic reset;

  boot_loader_if #(.addr_width(AW)) bus ();

  boot_loader #(.addr_width(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram_model [RAMN];
  logic [7:0] exp_tx [$];
  int         exp_wr [$];
  logic [7:0] payload [$];

  // UART transmitter: busy for a few random cycles after each start
  int   busy_cnt   = 0;
  logic busy_force = 1'b0;
  assign bus.tx_busy = busy_force | (busy_cnt != 0);
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= $urandom_range(1, 6);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // RAM with two-cycle read latency
  logic [7:0] ram [RAMN];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (bus.mem_write) ram[bus.mem_waddr] <= bus.mem_wdata;
    rd1           <= ram[bus.mem_raddr];
    bus.mem_rdata <= rd1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tx_start) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", int'(bus.tx_data), -1);
      else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        chk("tx_byte", int'(bus.tx_data), int'(e));
        $display("tx byte 0x%02h (expected 0x%02h)", bus.tx_data, e);
      end
    end
    if (bus.mem_write && bus.cpu_reset) begin
      int act;
      act = int'(bus.mem_waddr) * 256 + int'(bus.mem_wdata);
      if (exp_wr.size() == 0) chk("wr_unexpected", act, -1);
      else begin
        int e;
        e = exp_wr.pop_front();
        chk("loader_write", act, e);
        $display("loader write addr 0x%03h data 0x%02h", bus.mem_waddr, bus.mem_wdata);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_ack(input string name);
    int c;
    c = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && c < 4000) begin
      @(posedge clk);
      c++;
    end
    chk(name, exp_tx.size() + exp_wr.size(), 0);
    exp_tx.delete();
    exp_wr.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int w);
    send(8'((w >> 8) & 255));
    send(8'(w & 255));
  endtask

  // Writes land at (A + i) mod RAM size, then one 'K'
  task automatic cmd_load(input int a16);
    int n;
    n = payload.size();
    for (int i = 0; i < n; i++) begin
      int a;
      a = (a16 + i) % RAMN;
      exp_wr.push_back(a * 256 + int'(payload[i]));
      ram_model[a] = payload[i];
    end
    exp_tx.push_back(8'h4B);
    send(8'h4C);
    send_word(a16);
    send_word(n);
    for (int i = 0; i < n; i++) send(payload[i]);
    wait_ack("load_ack");
  endtask

  task automatic cmd_dump(input int a16, input int n);
`ifdef BOOT_LOADER_DUMP_EN
    for (int i = 0; i < n; i++) exp_tx.push_back(ram_model[(a16 + i) % RAMN]);
    exp_tx.push_back(8'h4B);
    send(8'h44);
    send_word(a16);
    send_word(n);
`else
    exp_tx.push_back(8'h3F);
    send(8'h44);
`endif
    wait_ack("dump_ack");
  endtask

  task automatic cmd_go(input int a16);
    exp_tx.push_back(8'h4B);
    send(8'h47);
    send_word(a16);
    wait_ack("go_ack");
    chk("start_address", int'(bus.start_address), a16 % RAMN);
    chk("cpu_released", int'(bus.cpu_reset), 0);
  endtask

  task automatic cmd_byte(input logic [7:0] b, input logic [7:0] rsp);
    exp_tx.push_back(rsp);
    send(b);
    wait_ack("byte_ack");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RAMN; i++) begin
      ram[i]       = 8'h00;
      ram_model[i] = 8'h00;
    end
    rd1            = 8'h00;
    bus.mem_rdata  = 8'h00;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.cpu_raddr  = '0;
    bus.cpu_waddr  = '0;
    bus.cpu_wdata  = 8'h00;
    bus.cpu_write  = 1'b0;
    bus.cpu_halted = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", int'(bus.cpu_reset), 1);
    chk("rst_start_address", int'(bus.start_address), 0);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_mem_write", int'(bus.mem_write), 0);
    chk("rst_mem_waddr", int'(bus.mem_waddr), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    payload = '{8'hAA, 8'hBB, 8'hCC};
    cmd_load(16'h0010);
    chk("load_keeps_reset", int'(bus.cpu_reset), 1);

    payload = '{8'h11, 8'h22};
    cmd_load(16'h01FF);

    cmd_dump(16'h0010, 2);
    cmd_byte(8'h5A, 8'h3F);

    // Ack must wait for the transmitter
    busy_force = 1'b1;
    payload.delete();
    exp_tx.push_back(8'h4B);
    send(8'h4C);
    send_word(16'h0000);
    send_word(0);
    repeat (50) @(posedge clk);
    chk("busy_hold", exp_tx.size(), 1);
    busy_force = 1'b0;
    wait_ack("busy_ack");

    for (int it = 0; it < 20; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        int n;
        n = $urandom_range(0, 6);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
        cmd_load($urandom_range(0, 65535));
      end else if (op == 1) begin
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h4C || b == 8'h47 || b == 8'h52 || b == 8'h44) b = 8'($urandom);
        cmd_byte(b, 8'h3F);
      end else if (op == 2) begin
        cmd_byte(8'h52, 8'h4B);
      end else begin
        cmd_dump($urandom_range(0, 65535), $urandom_range(0, 4));
      end
    end

    cmd_go(16'h0010);
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ra;
      logic [7:0]    wd;
      ra = AW'($urandom);
      wd = 8'($urandom);
      @(posedge clk); #1;
      bus.cpu_raddr = ra;
      bus.cpu_waddr = 9'h020;
      bus.cpu_wdata = wd;
      bus.cpu_write = 1'b1;
      #1;
      chk("pass_raddr", int'(bus.mem_raddr), int'(ra));
      chk("pass_waddr", int'(bus.mem_waddr), 32'h20);
      chk("pass_wdata", int'(bus.mem_wdata), int'(wd));
      chk("pass_write", int'(bus.mem_write), 1);
      ram_model[32'h20] = wd;
    end
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;

    // Non-reset bytes are ignored while running
    send(8'h5A);
    send(8'h4C);
    repeat (20) @(posedge clk);
    #1;
    chk("run_ignores_rx", int'(bus.cpu_reset), 0);

    exp_tx.push_back(8'h48);
    @(posedge clk); #1;
    bus.cpu_halted = 1'b1;
    @(posedge clk); #1;
    chk("halt_cpu_reset", int'(bus.cpu_reset), 1);
    wait_ack("halt_ack");
    bus.cpu_halted = 1'b0;

    cmd_dump(16'h0020, 1);

    cmd_go(16'hFF80);
    cmd_byte(8'h52, 8'h4B);
    chk("r_cpu_reset", int'(bus.cpu_reset), 1);

    // Reset mid-load: the first byte stays in RAM
    exp_wr.push_back(32'h40 * 256 + 32'h11);
    ram_model[32'h40] = 8'h11;
    send(8'h4C);
    send_word(16'h0040);
    send_word(3);
    send(8'h11);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midload_write", exp_wr.size(), 0);
    chk("midload_cpu_reset", int'(bus.cpu_reset), 1);
    exp_wr.delete();
    cmd_byte(8'h52, 8'h4B);
    cmd_dump(16'h003F, 3);

    repeat (20) @(posedge clk);
    chk("tx_left", exp_tx.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Serial program loader sitting between the UART byte receiver/transmitter and the CPU/RAM pair.
- While the CPU is held in reset, it owns the byte-wide RAM ports. It writes received bytes into RAM, then sets the CPU start address and releases the CPU.
- While the CPU runs, RAM ports pass straight through from the CPU. The loader reports a CPU halt over serial and can re-take the machine on command.

Parameters:
addr_width, 9, RAM byte-address width; must match the CPU and RAM instances.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high block reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
tx_data  output  8  byte to transmit
tx_start  output  1  one-cycle strobe, start transmission of tx_data
tx_busy  input  1  transmitter busy
cpu_raddr  input  addr_width  CPU read address
cpu_waddr  input  addr_width  CPU write address
cpu_wdata  input  8  CPU write data
cpu_write  input  1  CPU write enable
cpu_halted  input  1  CPU halted flag
cpu_reset  output  1  CPU reset, active-high
start_address  output  addr_width  CPU start address
mem_raddr  output  addr_width  RAM read address
mem_waddr  output  addr_width  RAM write address
mem_wdata  output  8  RAM write data
mem_write  output  1  RAM write enable
mem_rdata  input  8  RAM read data (RAM has two-cycle read latency)

Behaviour:
- Clocking and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - state IDLE; cpu_reset 1; start_address 0; tx_start 0; tx_data 0.
  - Loader mem_write 0; loader addresses 0; length counter 0.
- RAM mux:
  - cpu_reset=1: mem_* driven from loader registers.
  - cpu_reset=0: mem_raddr/mem_waddr/mem_wdata/mem_write = cpu_* combinationally.
- Byte protocol, multi-byte fields big-endian:
  - 'L'(0x4C) A1 A0 N1 N0 then N data bytes.
  - 'G'(0x47) A1 A0.
  - 'R'(0x52).
- Address fields: the 16-bit value is truncated to addr_width.
- States:
  - IDLE: act on rx_valid.
    - 'L' -> L_AH.
    - 'G' -> G_AH.
    - 'R' -> TX with 'K' (already in reset).
    - Any other byte -> TX with '?'(0x3F).
  - L_AH, L_AL: latch address bytes; L_AL -> L_NH.
  - L_NH, L_NL: latch length N (16 bit).
    - L_NL -> DATA, or -> TX 'K' if N=0.
  - DATA: on each rx_valid, register mem_waddr=addr, mem_wdata=rx_data, mem_write=1 for exactly one cycle (write lands the cycle after the strobe).
    - addr increments modulo 2^addr_width, so it wraps at the top of RAM.
    - N decrements; when N reaches 0 -> TX 'K'.
  - G_AH, G_AL: latch start address.
    - On the last byte: start_address=A, cpu_reset<=0 next cycle, -> TX 'K' then RUN.
  - RUN: cpu_reset=0.
    - Rising edge of cpu_halted (registered compare) -> cpu_reset<=1, TX 'H'(0x48), then IDLE.
    - rx byte 'R' -> cpu_reset<=1, TX 'K', then IDLE.
    - Other rx bytes in RUN are ignored.
  - TX: wait while tx_busy=1. When tx_busy=0, pulse tx_start one cycle with tx_data, then go to the return state (IDLE or RUN).
- Bytes arriving during TX are dropped; the UART is slow enough that the host must wait for each ack.
- Exactly one tx_start per ack.
- No loader write is ever issued while cpu_reset=0.
- A reset mid-load abandons the transfer. Bytes already written stay in RAM.

Optional Feature:
- Macro BOOT_LOADER_DUMP_EN.
- Defined: command 'D'(0x44) A1 A0 N1 N0 reads N bytes starting at A and transmits each, then 'K'. Only valid in IDLE.
  - Per byte: D_RD sets mem_raddr, D_W1, D_W2 (RAM latency), D_TX latches mem_rdata and transmits via the TX handshake.
  - Address increments with wrap; N=0 sends only 'K'.
- Undefined: 'D' is treated as an unknown command and answered with '?'.

Decomposition:
- Shared package: command byte constants (CMD_LOAD, CMD_GO, CMD_RESET, CMD_DUMP), reply constants (RSP_OK, RSP_HALT, RSP_ERR), state encoding localparams.
- One natural sub-module, boot_mem_mux: the purely combinational CPU/loader RAM port mux selected by cpu_reset. The FSM stays in boot_loader.

Test Plan:
- Reset, then 'L' 00 10 00 03 AA BB CC -> mem_write pulses at addrs 0x010,0x011,0x012 with AA,BB,CC; one tx_start with 'K'; cpu_reset stays 1.
- addr_width=9, 'L' 01 FF 00 02 11 22 -> writes 0x1FF=11, then 0x000=22 (wrap); 'K'.
- 'G' 00 10 -> start_address=0x010, cpu_reset falls, 'K' sent; CPU writes to 0x020 appear unchanged on mem_* ports.
- In RUN, raise cpu_halted -> cpu_reset=1 next cycle, 'H' transmitted once, state IDLE. Also: 'R' in RUN -> cpu_reset=1, 'K'.
- tx_busy held high 50 cycles after 'L' with N=0 -> no tx_start until tx_busy drops, then exactly one 'K'. Also: 0x5A in IDLE -> '?'.
- BOOT_LOADER_DUMP_EN: 'D' 00 10 00 02 after first load -> tx AA, BB, 'K'. Without the macro, 'D' -> '?'.
